// File: rtl/approx_mul_pipe.sv
// Pipelined unsigned approximate multiplier with per-beat column truncation and valid/ready flow control.
// Optional on-line error monitor enabled by defining APPROX_MUL_ERR_MON_EN.
module approx_mul_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int ERR_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_a,
    input  logic [WIDTH-1:0]             in_b,
    input  logic [$clog2(WIDTH+1)-1:0]   in_trunc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*WIDTH-1:0]           out_p,
    input  logic                         err_clr,
    output logic [ERR_W-1:0]             err_sum,
    output logic [ERR_W-1:0]             err_cnt
);

    localparam int PW = 2 * WIDTH;
    localparam int TW = $clog2(WIDTH + 1);

    logic [STAGES-1:0] valid_q, valid_d, load;
    logic [PW-1:0]     prod_q [STAGES];
    logic [PW-1:0]     prod_d [STAGES];
    logic [TW-1:0]     trunc_c;
    logic              in_fire;

    // Keeps only partial products in columns >= t, then adds half an LSB of the kept range.
    function automatic logic [PW-1:0] approx_mul(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [TW-1:0]    t);
        logic [PW-1:0] acc;
        acc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (a[i] && b[j] && (i + j >= int'(t))) begin
                    acc = acc + (PW'(1) << (i + j));
                end
            end
        end
        if (t != '0 && a != '0 && b != '0) begin
            acc = acc + (PW'(1) << (int'(t) - 1));
        end
        return acc;
    endfunction

    assign trunc_c = (in_trunc > TW'(WIDTH)) ? TW'(WIDTH) : in_trunc;

    // A slot may load when it is empty or its beat moves on; evaluated from the output backwards.
    always_comb begin
        logic chain;
        chain = out_ready;
        load  = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            load[s] = !valid_q[s] || chain;
            chain   = load[s];
        end
    end

    assign in_ready  = load[0] && !rst;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = valid_q[STAGES-1];
    assign out_p     = prod_q[STAGES-1];

    always_comb begin
        valid_d = valid_q;
        prod_d  = prod_q;
        if (load[0]) begin
            valid_d[0] = in_fire;
        end
        if (in_fire) begin
            prod_d[0] = approx_mul(in_a, in_b, trunc_c);
        end
        for (int s = 1; s < STAGES; s++) begin
            if (load[s]) begin
                valid_d[s] = valid_q[s-1];
                if (valid_q[s-1]) begin
                    prod_d[s] = prod_q[s-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                prod_q[s] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            prod_q  <= prod_d;
        end
    end

`ifdef APPROX_MUL_ERR_MON_EN
    localparam int SW = ((ERR_W > PW) ? ERR_W : PW) + 1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [PW-1:0]    exact_q [STAGES];
    logic [PW-1:0]    exact_d [STAGES];
    logic [PW-1:0]    diff;
    logic [SW-1:0]    sum_wide;
    logic [ERR_W-1:0] err_sum_q, err_sum_d, err_cnt_q, err_cnt_d;
    logic             out_fire;

    // The exact product rides alongside the approximate one, moving under the same enables.
    always_comb begin
        exact_d = exact_q;
        if (in_fire) begin
            exact_d[0] = PW'(in_a) * PW'(in_b);
        end
        for (int s = 1; s < STAGES; s++) begin
            if (load[s] && valid_q[s-1]) begin
                exact_d[s] = exact_q[s-1];
            end
        end
    end

    assign out_fire = out_valid && out_ready;
    assign diff     = (exact_q[STAGES-1] >= out_p) ? (exact_q[STAGES-1] - out_p)
                                                   : (out_p - exact_q[STAGES-1]);
    assign sum_wide = SW'(err_sum_q) + SW'(diff);

    always_comb begin
        err_sum_d = err_sum_q;
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_sum_d = '0;
            err_cnt_d = '0;
        end else if (out_fire) begin
            err_sum_d = (sum_wide > SW'(ERR_MAX)) ? ERR_MAX : sum_wide[ERR_W-1:0];
            err_cnt_d = (err_cnt_q == ERR_MAX) ? err_cnt_q : err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sum_q <= '0;
            err_cnt_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                exact_q[s] <= '0;
            end
        end else begin
            err_sum_q <= err_sum_d;
            err_cnt_q <= err_cnt_d;
            exact_q   <= exact_d;
        end
    end

    assign err_sum = err_sum_q;
    assign err_cnt = err_cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_sum = '0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Directed self-checking bench for approx_mul_pipe (WIDTH=8, STAGES=2); expected products are hand-computed.
// Error-monitor checks follow APPROX_MUL_ERR_MON_EN.
module tb_approx_mul_pipe;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;
    localparam int ERR_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic [3:0]        in_trunc;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_p;
    logic              err_clr;
    logic [ERR_W-1:0]  err_sum;
    logic [ERR_W-1:0]  err_cnt;

    int assert_count = 0;
    int fail_count   = 0;

    logic [7:0]  s_a [8];
    logic [7:0]  s_b [8];
    logic [3:0]  s_t [8];
    logic [15:0] s_p [8];
    logic [15:0] res_p;
    int          res_lat;

    approx_mul_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .ERR_W(ERR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_trunc  (in_trunc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .err_clr   (err_clr),
        .err_sum   (err_sum),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One isolated beat on an empty pipe; returns product and cycles from acceptance to out_valid.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [3:0] t,
                                 input logic clr_on_out, output logic [15:0] p, output int lat);
        in_a     = a;
        in_b     = b;
        in_trunc = t;
        in_valid = 1'b1;
        #1;
        checkOutput("single_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        p       = out_p;
        err_clr = clr_on_out;
        @(posedge clk); #1;
        err_clr = 1'b0;
    endtask

    // Streams n beats from the s_* tables; out_ready is held low for the first hold cycles.
    task automatic runStream(input int n, input int hold);
        int idx = 0;
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 100) begin
            cyc++;
            in_valid = (idx < n);
            if (idx < n) begin
                in_a     = s_a[idx];
                in_b     = s_b[idx];
                in_trunc = s_t[idx];
            end
            out_ready = (cyc > hold);
            #1;
            if (hold > 0 && cyc == hold) begin
                checkOutput("bp_accepted", 64'(idx), 64'(STAGES));
                checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            end
            if (out_valid && !out_ready) begin
                checkOutput("bp_hold_p", 64'(out_p), 64'(s_p[0]));
            end
            if (out_valid && out_ready) begin
                checkOutput($sformatf("stream_p%0d", got), 64'(out_p), 64'(s_p[got]));
                got++;
            end
            if (in_valid && in_ready) begin
                idx++;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("stream_count", 64'(got), 64'(n));
        repeat (3) begin
            checkOutput("stream_no_extra", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_trunc  = '0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_p", 64'(out_p), 64'd0);
        checkOutput("rst_err_sum", 64'(err_sum), 64'd0);
        checkOutput("rst_err_cnt", 64'(err_cnt), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        applyStimulus(8'd255, 8'd255, 4'd0, 1'b0, res_p, res_lat);
        checkOutput("exact_255x255", 64'(res_p), 64'd65025);
        checkOutput("latency", 64'(res_lat), 64'd2);
        applyStimulus(8'd15, 8'd15, 4'd4, 1'b0, res_p, res_lat);
        checkOutput("t4_15x15", 64'(res_p), 64'd184);
        applyStimulus(8'd0, 8'd15, 4'd4, 1'b0, res_p, res_lat);
        checkOutput("t4_zero_no_bias", 64'(res_p), 64'd0);
        applyStimulus(8'd255, 8'd255, 4'd15, 1'b0, res_p, res_lat);
        checkOutput("clamp_t15", 64'(res_p), 64'd63360);

        s_a[0] = 8'd15; s_b[0] = 8'd15; s_t[0] = 4'd0; s_p[0] = 16'd225;
        s_a[1] = 8'd15; s_b[1] = 8'd15; s_t[1] = 4'd4; s_p[1] = 16'd184;
        s_a[2] = 8'd7;  s_b[2] = 8'd7;  s_t[2] = 4'd0; s_p[2] = 16'd49;
        s_a[3] = 8'd7;  s_b[3] = 8'd7;  s_t[3] = 4'd4; s_p[3] = 16'd24;
        runStream(4, 0);

        for (int k = 0; k < 5; k++) begin
            s_a[k] = 8'(k + 1);
            s_b[k] = 8'd3;
            s_t[k] = 4'd0;
            s_p[k] = 16'(3 * (k + 1));
        end
        runStream(5, 5);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 8'd9;
        in_b      = 8'd9;
        in_trunc  = 4'd0;
        @(posedge clk); #1;
        in_a = 8'd10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("fill_out_valid", 64'(out_valid), 64'd1);
        rst      = 1'b1;
        in_valid = 1'b1;
        #1;
        checkOutput("rst_mid_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checkOutput("after_rst_in_ready", 64'(in_ready), 64'd1);
        repeat (4) begin
            checkOutput("after_rst_no_stale", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end

`ifdef APPROX_MUL_ERR_MON_EN
        checkOutput("mon_rst_sum", 64'(err_sum), 64'd0);
        applyStimulus(8'd15, 8'd15, 4'd4, 1'b0, res_p, res_lat);
        applyStimulus(8'd255, 8'd255, 4'd0, 1'b0, res_p, res_lat);
        checkOutput("mon_err_sum", 64'(err_sum), 64'd41);
        checkOutput("mon_err_cnt", 64'(err_cnt), 64'd2);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        checkOutput("mon_clr_sum", 64'(err_sum), 64'd0);
        checkOutput("mon_clr_cnt", 64'(err_cnt), 64'd0);
        applyStimulus(8'd15, 8'd15, 4'd4, 1'b1, res_p, res_lat);
        checkOutput("mon_clr_xfer_sum", 64'(err_sum), 64'd0);
        checkOutput("mon_clr_xfer_cnt", 64'(err_cnt), 64'd0);
`else
        applyStimulus(8'd15, 8'd15, 4'd4, 1'b0, res_p, res_lat);
        checkOutput("mon_off_sum", 64'(err_sum), 64'd0);
        checkOutput("mon_off_cnt", 64'(err_cnt), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/approx_mul_pipe.md
Name: approx_mul_pipe

Overview:
- Parametrised unsigned approximate multiplier with column truncation selected at run time, pipelined, with valid/ready flow control.
- Successor to the fixed 8x8 combinational approximate multipliers. Adds a generic width, a per-transaction accuracy level, pipelining with backpressure, and an optional on-line error monitor.
- Sits between an operand source and a result sink in the evaluation datapath. Used for power/accuracy sweeps without re-synthesis.

Parameters:
- WIDTH, 8, operand width in bits. Result is 2*WIDTH bits. Legal range 4..16.
- STAGES, 2, pipeline register stages from input to output. Legal range 1..4. Equals latency in cycles with no backpressure.
- ERR_W, 32, width of the error-monitor accumulator. Used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  unsigned operand A.
- in_b  in  WIDTH  unsigned operand B.
- in_trunc  in  $clog2(WIDTH+1)  number of dropped LSB partial-product columns (T) for this beat.
- out_valid  out  1  result beat valid.
- out_ready  in  1  sink accepts the result.
- out_p  out  2*WIDTH  approximate product.
- err_clr  in  1  clears the error monitor (optional feature).
- err_sum  out  ERR_W  saturating sum of |exact - approx| (optional feature).
- err_cnt  out  ERR_W  saturating count of results delivered (optional feature).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Transfers: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Truncation clamp: T = min(in_trunc, WIDTH). T is captured with the operands and travels with the beat, so mode changes never affect beats already in flight.
- Arithmetic: approx = sum over all i,j with i+j >= T of (A[i]&B[j])<<(i+j).
  - If T>0 and A!=0 and B!=0, add a rounding bias of 2^(T-1).
  - T=0 gives the exact product.
  - The result never exceeds 2*WIDTH bits. No saturation is needed.
- Pipeline: STAGES register slots, each with a valid bit.
  - A slot loads when it is empty or its content moves downstream in the same cycle.
  - in_ready = first slot empty or advancing. It is combinational from out_ready through the slot valid bits.
  - The arithmetic may be split across stages freely; only latency and ordering are specified.
- Latency: exactly STAGES cycles from input transfer to out_valid when out_ready stays high.
- Throughput: 1 beat per cycle when out_ready is high continuously.
- Backpressure: with out_ready low, the pipeline fills and holds up to STAGES beats; in_ready then goes low.
  - out_p is stable while out_valid & !out_ready.
  - No beat is dropped or duplicated, and order is preserved.
- Simultaneous events: when full and out_ready rises, an output transfer and an input transfer both occur in the same cycle.
- Reset values: every valid bit = 0, out_valid = 0, out_p = 0, in_ready = 0 while rst is high and 1 in the first cycle after.
- Reset mid-operation: all in-flight beats are discarded. No partial result is ever presented.
- Inputs are ignored while rst is high.
- X-free: in_a, in_b and in_trunc are don't-care when in_valid is low.

Optional Feature:
- Macro: APPROX_MUL_ERR_MON_EN.
- With the macro defined, the block carries the exact product alongside each beat.
  - On every output transfer: err_sum += |exact - approx| and err_cnt += 1. Both saturate at 2^ERR_W-1.
  - err_clr (synchronous) zeroes both. If err_clr coincides with a transfer, the clear wins and the transfer is not counted.
  - rst zeroes both.
- Without the macro: no exact-path logic is built, err_sum and err_cnt are tied to 0, and err_clr is ignored.

Test Plan:
- WIDTH=8, STAGES=2, T=0, A=255, B=255, out_ready=1 -> out_p=65025 (0xFE01), out_valid exactly 2 cycles after acceptance.
- T=4, A=15, B=15 -> out_p=184 (176 kept + bias 8). Same with A=0, B=15 -> out_p=0 (no bias).
- in_trunc=15 (clamped to 8), A=255, B=255 -> out_p equals the T=8 model value. Back-to-back beats with alternating T=0/T=4 -> each result matches its own T.
- out_ready low for 5 cycles while streaming beats 1..5 -> exactly 2 accepted, in_ready low, out_p stable. Release -> results 1..5 delivered in order, no gaps or duplicates.
- rst asserted for 1 cycle with 2 beats in flight -> next cycle out_valid=0, in_ready=1. No stale result ever appears.
- With APPROX_MUL_ERR_MON_EN, beats (15,15,T=4) and (255,255,T=0) -> err_sum=41, err_cnt=2. err_clr -> both 0. err_clr on a transfer cycle -> both remain 0.
